des_ahb_master: RTL

AHB-Lite master controller that drives the Triple-DES AHB-Lite slave register map. It accepts a key/mode configuration and 64-bit plaintext/ciphertext blocks from a local valid/ready interface, and issues the matching single-beat AHB writes. After a fixed compute interval it issues an AHB read of the result register and returns the 64-bit result on a local valid/ready output. It sits between a local data source/sink (DMA or CPU-side FIFO) and the DES slave on the same AHB-Lite bus.

---
 rtl/des_ahb_pkg.sv | 26 ++
 rtl/des_ahb_master_if.sv | 19 +
 rtl/des_ahb_wait_ctr.sv | 22 ++
 rtl/des_ahb_master.sv | 137 +++++++++++++
 4 files changed

// File: rtl/des_ahb_pkg.sv
// Shared encodings for the Triple-DES AHB-Lite master: bus constants, register offsets, FSM states.
package des_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_DW      = 3'b011;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'h3;

  localparam logic [3:0] REG_MODE   = 4'd0;
  localparam logic [3:0] REG_KEY1   = 4'd1;
  localparam logic [3:0] REG_KEY2   = 4'd2;
  localparam logic [3:0] REG_KEY3   = 4'd3;
  localparam logic [3:0] REG_DATA   = 4'd4;
  localparam logic [3:0] REG_RESULT = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CFG, ST_BLK, ST_WAIT, ST_RD, ST_RDATA, ST_HOLD, ST_ERROR
  } state_e;

  // The slave decodes word indices, so the offset is added directly to the base.
  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [3:0] idx);
    return base + {28'd0, idx};
  endfunction

endpackage

// File: rtl/des_ahb_master_if.sv
// AHB-Lite bus bundle between the DES master and the DES slave.
interface des_ahb_master_if;
  logic        HREADY;
  logic        HRESP;
  logic [63:0] HRDATA;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [63:0] HWDATA;

  modport master (input HREADY, HRESP, HRDATA,
                  output HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA);
  modport slave  (output HREADY, HRESP, HRDATA,
                  input HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA);
endinterface

// File: rtl/des_ahb_wait_ctr.sv
// Loadable down-counter timing the gap between the data write and the result read.
module des_ahb_wait_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            cnt_q <= '0;
    else if (load_i)                    cnt_q <= load_val_i;
    else if (en_i && (cnt_q != '0))     cnt_q <= cnt_q - 1'b1;
  end

  // Asserted on the last waiting cycle: the decrement to zero coincides with leaving WAIT.
  assign done_o = (cnt_q == W'(1));
endmodule

// File: rtl/des_ahb_master.sv
// AHB-Lite master sequencing config/block writes and result reads to the Triple-DES slave.
// Optional: DES_MASTER_ERRCHK_EN enables HRESP error trapping into a sticky ERROR state.
module des_ahb_master
  import des_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hAAAAAAA0,
  parameter int          RESULT_WAIT = 7
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  des_ahb_master_if.master         ahb,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic                     cfg_enc_dec,
  input  logic [63:0]              cfg_key1,
  input  logic [63:0]              cfg_key2,
  input  logic [63:0]              cfg_key3,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  input  logic [63:0]              blk_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [63:0]              res_data,
  output logic                     keyed,
  output logic                     busy,
  output logic                     err
);
  state_e           state_q;
  logic [2:0]       idx_q;
  logic [31:0]      haddr_q;
  logic [1:0]       htrans_q;
  logic             hwrite_q;
  logic [63:0]      hwdata_q;
  logic             cfg_rdy_q, res_vld_q, keyed_q;
  logic             mode_q;
  logic [2:0][63:0] key_q;
  logic [63:0]      blk_q, res_q, wsel;
  logic             wait_done, wait_load, blk_fire, cfg_fire, dph;

  assign blk_ready = cfg_rdy_q && keyed_q && !cfg_valid;
  assign cfg_fire  = cfg_valid && cfg_rdy_q;
  assign blk_fire  = blk_valid && blk_ready;
  assign wait_load = (state_q == ST_BLK) && (idx_q == 3'd1) && ahb.HREADY;
  // A data phase is in flight during CFG idx 1..4, BLK idx 1 and RDATA.
  assign dph = ((state_q == ST_CFG) && (idx_q != 3'd0)) ||
               ((state_q == ST_BLK) && (idx_q == 3'd1)) || (state_q == ST_RDATA);

  always_comb begin
    wsel = key_q[2];
    case (idx_q)
      3'd0:    wsel = {63'd0, mode_q};
      3'd1:    wsel = key_q[0];
      3'd2:    wsel = key_q[1];
      default: wsel = key_q[2];
    endcase
  end

  des_ahb_wait_ctr #(.W(8)) u_wait (
    .clk(HCLK), .rst(HRESET), .load_i(wait_load), .en_i(ahb.HREADY),
    .load_val_i(8'(RESULT_WAIT)), .done_o(wait_done)
  );

`ifdef DES_MASTER_ERRCHK_EN
  logic err_q;
  assign err = err_q;
`else
  logic unused_hresp;
  assign unused_hresp = ahb.HRESP;
  assign err = 1'b0;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;  idx_q <= '0;  haddr_q <= '0;  htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;    hwdata_q <= '0; cfg_rdy_q <= 1'b0; res_vld_q <= 1'b0;
      res_q <= '0;         keyed_q <= 1'b0; mode_q <= 1'b0; key_q <= '0; blk_q <= '0;
`ifdef DES_MASTER_ERRCHK_EN
      err_q <= 1'b0;
`endif
    end else begin
`ifdef DES_MASTER_ERRCHK_EN
      if (dph && ahb.HRESP) begin
        state_q <= ST_ERROR; htrans_q <= HTRANS_IDLE; hwrite_q <= 1'b0;
        cfg_rdy_q <= 1'b0;   res_vld_q <= 1'b0;       err_q <= 1'b1;
      end else
`endif
      case (state_q)
        ST_IDLE: begin
          cfg_rdy_q <= 1'b1;
          if (cfg_fire) begin
            mode_q <= cfg_enc_dec; key_q <= {cfg_key3, cfg_key2, cfg_key1};
            state_q <= ST_CFG; idx_q <= '0; cfg_rdy_q <= 1'b0;
            haddr_q <= reg_addr(BASE_ADDR, REG_MODE); htrans_q <= HTRANS_NONSEQ; hwrite_q <= 1'b1;
          end else if (blk_fire) begin
            blk_q <= blk_data; state_q <= ST_BLK; idx_q <= '0; cfg_rdy_q <= 1'b0;
            haddr_q <= reg_addr(BASE_ADDR, REG_DATA); htrans_q <= HTRANS_NONSEQ; hwrite_q <= 1'b1;
          end
        end
        ST_CFG: if (ahb.HREADY) begin
          // idx 0..3 are address phases; idx 4 is the trailing key3 data phase.
          if (idx_q != 3'd4) hwdata_q <= wsel;
          if (idx_q < 3'd3) haddr_q <= reg_addr(BASE_ADDR, REG_MODE + 4'(idx_q) + 4'd1);
          else if (idx_q == 3'd3) begin htrans_q <= HTRANS_IDLE; hwrite_q <= 1'b0; end
          if (idx_q == 3'd4) begin state_q <= ST_IDLE; keyed_q <= 1'b1; cfg_rdy_q <= 1'b1; end
          else idx_q <= idx_q + 3'd1;
        end
        ST_BLK: if (ahb.HREADY) begin
          if (idx_q == 3'd0) begin
            hwdata_q <= blk_q; htrans_q <= HTRANS_IDLE; hwrite_q <= 1'b0; idx_q <= 3'd1;
          end else state_q <= ST_WAIT;
        end
        ST_WAIT: if (ahb.HREADY && wait_done) begin
          state_q <= ST_RD; haddr_q <= reg_addr(BASE_ADDR, REG_RESULT);
          htrans_q <= HTRANS_NONSEQ; hwrite_q <= 1'b0;
        end
        ST_RD: if (ahb.HREADY) begin htrans_q <= HTRANS_IDLE; state_q <= ST_RDATA; end
        ST_RDATA: if (ahb.HREADY) begin res_q <= ahb.HRDATA; res_vld_q <= 1'b1; state_q <= ST_HOLD; end
        ST_HOLD: if (res_ready) begin res_vld_q <= 1'b0; state_q <= ST_IDLE; cfg_rdy_q <= 1'b1; end
        default: state_q <= state_q;
      endcase
    end
  end

  assign ahb.HADDR     = haddr_q;
  assign ahb.HTRANS    = htrans_q;
  assign ahb.HWRITE    = hwrite_q;
  assign ahb.HWDATA    = hwdata_q;
  assign ahb.HSIZE     = HSIZE_DW;
  assign ahb.HBURST    = HBURST_SINGLE;
  assign ahb.HPROT     = HPROT_DATA;
  assign ahb.HMASTLOCK = 1'b0;
  assign cfg_ready     = cfg_rdy_q;
  assign res_valid     = res_vld_q;
  assign res_data      = res_q;
  assign keyed         = keyed_q;
  assign busy          = (state_q != ST_IDLE);
endmodule
